// File: rtl/axis_tdest_sequencer_pkg.sv
// Shared types and helpers for the AXI4-Stream tdest sequencer.
// Covers the mode encoding, the destination limit and config clamping.
package axis_tdest_pkg;

  typedef enum logic {
    MODE_ROTATE = 1'b0,
    MODE_FIXED  = 1'b1
  } mode_e;

  localparam int unsigned MAX_NUM_DEST = 16;

  // Active count is forced into 1..num_dest.
  function automatic logic [4:0] clamp_num_active(input logic [4:0] n, input int unsigned num_dest);
    if (n == 5'd0) return 5'd1;
    if (32'(n) > num_dest) return 5'(num_dest);
    return n;
  endfunction

  function automatic logic [3:0] clamp_fixed_dest(input logic [3:0] d, input int unsigned num_dest);
    if (32'(d) >= num_dest) return 4'(num_dest - 1);
    return d;
  endfunction

endpackage

// File: rtl/axis_tdest_sequencer_if.sv
// AXI4-Stream bundle used on both sides of the sequencer.
// The input side does not carry tdest, so the slave modport omits it.
interface axis_tdest_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEST_WIDTH = 32
);
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [DATA_WIDTH-1:0] tdata;
  logic [DEST_WIDTH-1:0] tdest;

  modport master (output tvalid, tlast, tdata, tdest, input tready);
  modport slave  (input tvalid, tlast, tdata, output tready);
endinterface

// File: rtl/axis_tdest_sequencer_skid.sv
// Two-entry skid buffer with a registered output stage and registered ready.
// The output register drives the bus; the skid slot absorbs the beat in flight on a stall.
module axis_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  logic             r_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_skid_data;

  logic w_in_hs;
  logic w_out_free;
  logic w_skid_valid_next;

  assign w_in_hs    = i_valid & r_ready;
  assign w_out_free = !r_out_valid | i_ready;

  // Ready for the next cycle depends only on whether the skid slot will be occupied.
  assign w_skid_valid_next = w_out_free ? 1'b0 : (r_skid_valid | w_in_hs);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ready      <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
    end else begin
      r_ready <= !w_skid_valid_next;
      if (w_out_free) begin
        if (r_skid_valid) begin
          r_out_valid  <= 1'b1;
          r_out_data   <= r_skid_data;
          r_skid_valid <= 1'b0;
        end else begin
          r_out_valid <= w_in_hs;
          if (w_in_hs) r_out_data <= i_data;
        end
      end else if (w_in_hs) begin
        r_skid_valid <= 1'b1;
        r_skid_data  <= i_data;
      end
    end
  end

  assign o_ready = r_ready;
  assign o_valid = r_out_valid;
  assign o_data  = r_out_data;

endmodule

// File: rtl/axis_tdest_sequencer.sv
// Tags each input packet with a destination (rotating or fixed) and forwards it
// through a registered skid stage; counts packets completed at the output.
module axis_tdest_sequencer
  import axis_tdest_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int DEST_WIDTH    = 32,
  parameter int NUM_DEST      = 2,
  parameter int PKTS_PER_DEST = 1
) (
  input  logic                          clk,
  input  logic                          resetn,
  axis_tdest_sequencer_if.slave         s_axis,
  axis_tdest_sequencer_if.master        m_axis,
  input  logic                          cfg_mode,
  input  logic [3:0]                    cfg_fixed_dest,
  input  logic [4:0]                    cfg_num_active,
  output logic [3:0]                    sts_dest,
  output logic [31:0]                   sts_pkt_count
);

  localparam int PW = DATA_WIDTH + DEST_WIDTH + 1;
  localparam logic [15:0] PKT_LAST = 16'(PKTS_PER_DEST - 1);

  logic        r_in_packet;
  mode_e       r_mode;
  logic [4:0]  r_num_act;
  logic [3:0]  r_dest;
  logic [3:0]  r_rot_dest;
  logic [15:0] r_pkt_cnt;
  logic [31:0] r_pkt_count;

  logic          w_s_ready;
  logic          w_in_hs;
  mode_e         w_mode;
  logic [4:0]    w_num_act;
  logic          w_wrap;
  logic [3:0]    w_rot_eff;
  logic [15:0]   w_cnt_eff;
  logic [3:0]    w_rot_next;
  logic [3:0]    w_dest;
  logic [PW-1:0] w_payload_in;
  logic [PW-1:0] w_payload_out;

  assign w_in_hs = s_axis.tvalid & w_s_ready;

  // Config comes live from the ports at a packet boundary and from the latched copy mid-packet.
  always_comb begin
    w_mode    = r_in_packet ? r_mode : mode_e'(cfg_mode);
    w_num_act = r_in_packet ? r_num_act : clamp_num_active(cfg_num_active, NUM_DEST);
    w_wrap    = {1'b0, r_rot_dest} >= w_num_act;
    w_rot_eff = w_wrap ? 4'd0 : r_rot_dest;
    w_cnt_eff = w_wrap ? 16'd0 : r_pkt_cnt;
    w_rot_next = ({1'b0, w_rot_eff} == w_num_act - 5'd1) ? 4'd0 : w_rot_eff + 4'd1;
    if (r_in_packet)
      w_dest = r_dest;
    else if (w_mode == MODE_FIXED)
      w_dest = clamp_fixed_dest(cfg_fixed_dest, NUM_DEST);
    else
      w_dest = w_rot_eff;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_in_packet <= 1'b0;
      r_mode      <= MODE_ROTATE;
      r_num_act   <= 5'd1;
      r_dest      <= 4'd0;
      r_rot_dest  <= 4'd0;
      r_pkt_cnt   <= 16'd0;
    end else if (w_in_hs) begin
      if (!r_in_packet) begin
        r_mode    <= w_mode;
        r_num_act <= w_num_act;
        r_dest    <= w_dest;
      end
      r_in_packet <= !s_axis.tlast;
      // Fixed-mode packets leave the rotation position untouched.
      if (w_mode == MODE_ROTATE) begin
        if (s_axis.tlast && (w_cnt_eff == PKT_LAST)) begin
          r_pkt_cnt  <= 16'd0;
          r_rot_dest <= w_rot_next;
        end else begin
          r_pkt_cnt  <= s_axis.tlast ? w_cnt_eff + 16'd1 : w_cnt_eff;
          r_rot_dest <= w_rot_eff;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      r_pkt_count <= 32'd0;
    else if (m_axis.tvalid & m_axis.tready & m_axis.tlast)
      r_pkt_count <= r_pkt_count + 32'd1;
  end

  assign w_payload_in = {s_axis.tlast, DEST_WIDTH'(w_dest), s_axis.tdata};

  axis_skid_buffer #(.WIDTH(PW)) u_skid (
    .clk     (clk),
    .resetn  (resetn),
    .i_valid (s_axis.tvalid),
    .o_ready (w_s_ready),
    .i_data  (w_payload_in),
    .o_valid (m_axis.tvalid),
    .i_ready (m_axis.tready),
    .o_data  (w_payload_out)
  );

  assign s_axis.tready = w_s_ready;
  assign {m_axis.tlast, m_axis.tdest, m_axis.tdata} = w_payload_out;
  assign sts_dest      = w_dest;
  assign sts_pkt_count = r_pkt_count;

endmodule

// File: tb/tb_axis_tdest_sequencer.sv
// Self-checking bench: packet-level reference model of destination assignment,
// per-cycle output comparison, and directed destination sequences.
module tb_axis_tdest_sequencer;

  localparam int DW  = 32;
  localparam int TW  = 32;
  localparam int ND  = 4;
  localparam int PPD = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  axis_tdest_sequencer_if #(.DATA_WIDTH(DW), .DEST_WIDTH(TW)) s_if ();
  axis_tdest_sequencer_if #(.DATA_WIDTH(DW), .DEST_WIDTH(TW)) m_if ();

  logic        cfg_mode;
  logic [3:0]  cfg_fixed_dest;
  logic [4:0]  cfg_num_active;
  logic [3:0]  sts_dest;
  logic [31:0] sts_pkt_count;

  axis_tdest_sequencer #(
    .DATA_WIDTH(DW), .DEST_WIDTH(TW), .NUM_DEST(ND), .PKTS_PER_DEST(PPD)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .s_axis         (s_if.slave),
    .m_axis         (m_if.master),
    .cfg_mode       (cfg_mode),
    .cfg_fixed_dest (cfg_fixed_dest),
    .cfg_num_active (cfg_num_active),
    .sts_dest       (sts_dest),
    .sts_pkt_count  (sts_pkt_count)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] data;
    logic        last;
    int          dest;
  } beat_t;

  beat_t exp_q[$];
  int    dest_log[$];
  int    m_in_pkt = 0, m_rot = 0, m_cnt = 0, m_num = 1, m_pkt_fixed = 0, m_cur_dest = 0;
  int    exp_pkts = 0;
  int    out_first = 1, out_dest = 0;
  bit    prev_stall = 0;
  logic [31:0] sv_data, sv_dest;
  logic        sv_last;

  function automatic int clamp_n(input int n);
    if (n == 0) return 1;
    if (n > ND) return ND;
    return n;
  endfunction

  function automatic int clamp_f(input int d);
    return (d >= ND) ? ND - 1 : d;
  endfunction

  function automatic int predicted_dest();
    if (m_in_pkt != 0) return m_cur_dest;
    if (cfg_mode) return clamp_f(int'(cfg_fixed_dest));
    return (m_rot >= clamp_n(int'(cfg_num_active))) ? 0 : m_rot;
  endfunction

  task automatic model_accept(input logic [31:0] d, input logic last);
    beat_t b;
    if (m_in_pkt == 0) begin
      m_num       = clamp_n(int'(cfg_num_active));
      m_pkt_fixed = int'(cfg_mode);
      if (cfg_mode) m_cur_dest = clamp_f(int'(cfg_fixed_dest));
      else begin
        if (m_rot >= m_num) begin m_rot = 0; m_cnt = 0; end
        m_cur_dest = m_rot;
      end
    end
    b.data = d; b.last = last; b.dest = m_cur_dest;
    exp_q.push_back(b);
    if (last) begin
      m_in_pkt = 0;
      if (m_pkt_fixed == 0) begin
        m_cnt++;
        if (m_cnt == PPD) begin m_cnt = 0; m_rot = (m_rot + 1) % m_num; end
      end
    end else m_in_pkt = 1;
  endtask

  // Inputs change only just after posedge, so the negedge sees what the next edge will act on.
  always @(negedge clk) begin
    if (!resetn) begin
      exp_q.delete();
      m_in_pkt = 0; m_rot = 0; m_cnt = 0; exp_pkts = 0;
      out_first = 1; prev_stall = 0;
    end else begin
      chk("pkt_count", sts_pkt_count, 32'(exp_pkts));
      chk("sts_dest", sts_dest, 4'(predicted_dest()));
      if (prev_stall) begin
        chk("stall_data", m_if.tdata, sv_data);
        chk("stall_last", m_if.tlast, sv_last);
        chk("stall_dest", m_if.tdest, sv_dest);
      end
      if (m_if.tvalid) begin
        if (exp_q.size() == 0) chk("spurious_valid", m_if.tvalid, 0);
        else begin
          chk("out_data", m_if.tdata, exp_q[0].data);
          chk("out_last", m_if.tlast, exp_q[0].last);
          chk("out_dest", m_if.tdest, 32'(exp_q[0].dest));
          if (m_if.tready) begin
            void'(exp_q.pop_front());
            if (out_first == 0) chk("dest_const", m_if.tdest, 32'(out_dest));
            else out_dest = int'(m_if.tdest);
            out_first = int'(m_if.tlast);
            if (m_if.tlast) begin
              exp_pkts++;
              dest_log.push_back(int'(m_if.tdest));
            end
          end
        end
      end
      prev_stall = m_if.tvalid & !m_if.tready;
      sv_data = m_if.tdata; sv_last = m_if.tlast; sv_dest = m_if.tdest;
      if (s_if.tvalid & s_if.tready) model_accept(s_if.tdata, s_if.tlast);
    end
  end

  // ---------------- stimulus ----------------
  bit rand_ready = 0;
  initial forever begin
    @(posedge clk); #1;
    if (rand_ready) m_if.tready = 1'($urandom_range(0, 1));
  end

  task automatic send_beat(input logic [31:0] d, input logic last);
    logic ok;
    int t = 0;
    s_if.tvalid = 1'b1; s_if.tdata = d; s_if.tlast = last;
    do begin
      @(negedge clk); ok = s_if.tready;
      @(posedge clk); #1; t++;
    end while (!ok && t < 200);
    if (!ok) chk("in_handshake_timeout", s_if.tready, 1);
    s_if.tvalid = 1'b0;
  endtask

  task automatic send_pkt(input int len, input int gap_max);
    for (int i = 0; i < len; i++) begin
      send_beat($urandom, i == len - 1);
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || m_if.tvalid) && t < 2000) begin @(negedge clk); t++; end
    chk("drain_queue_empty", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic check_log(input string name, input int exp[$]);
    chk({name, "_count"}, dest_log.size(), exp.size());
    for (int i = 0; i < exp.size() && i < dest_log.size(); i++)
      chk($sformatf("%s_dest%0d", name, i), dest_log[i], exp[i]);
    dest_log.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_m_tvalid"}, m_if.tvalid, 0);
    chk({tag, "_m_tlast"}, m_if.tlast, 0);
    chk({tag, "_m_tdata"}, m_if.tdata, 0);
    chk({tag, "_m_tdest"}, m_if.tdest, 0);
    chk({tag, "_s_tready"}, s_if.tready, 0);
    chk({tag, "_sts_dest"}, sts_dest, 0);
    chk({tag, "_sts_pkt_count"}, sts_pkt_count, 0);
  endtask

  initial begin
    int q[$];
    s_if.tvalid = 1'b0; s_if.tlast = 1'b0; s_if.tdata = '0; s_if.tdest = '0;
    m_if.tready = 1'b1;
    cfg_mode = 1'b0; cfg_fixed_dest = 4'd0; cfg_num_active = 5'd4;

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1; resetn = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("tready_after_release", s_if.tready, 1);
    @(posedge clk); #1;

    // Rotation through all four destinations, two packets each.
    for (int p = 0; p < 8; p++) send_pkt(3, 0);
    drain();
    q = {0, 0, 1, 1, 2, 2, 3, 3}; check_log("rotate4", q);
    chk("pkt_count_rotate4", sts_pkt_count, 8);

    cfg_num_active = 5'd3;
    for (int p = 0; p < 7; p++) send_pkt(1, 0);
    drain();
    q = {0, 0, 1, 1, 2, 2, 0}; check_log("single_beat3", q);

    cfg_num_active = 5'd4;
    send_pkt(2, 0);
    cfg_mode = 1'b1; cfg_fixed_dest = 4'd2;
    for (int p = 0; p < 3; p++) send_pkt(2, 1);
    cfg_mode = 1'b0;
    send_pkt(2, 0);
    cfg_mode = 1'b1; cfg_fixed_dest = 4'd9;
    send_pkt(2, 0);
    cfg_mode = 1'b0;
    drain();
    q = {0, 2, 2, 2, 1, 3}; check_log("fixed", q);

    // Shrink active count while a dest-3 packet is in flight.
    send_pkt(1, 0);
    send_pkt(1, 0);
    send_pkt(1, 0);
    send_beat($urandom, 1'b0);
    send_beat($urandom, 1'b0);
    cfg_num_active = 5'd2;
    send_beat($urandom, 1'b0);
    send_beat($urandom, 1'b1);
    send_pkt(2, 0);
    drain();
    q = {1, 2, 2, 3, 0}; check_log("shrink", q);

    rand_ready = 1;
    for (int p = 0; p < 1000; p++) begin
      int len;
      cfg_mode       = ($urandom_range(0, 3) == 0);
      cfg_fixed_dest = 4'($urandom_range(0, 15));
      cfg_num_active = 5'($urandom_range(0, 7));
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          cfg_mode       = ~cfg_mode;
          cfg_num_active = 5'($urandom_range(0, 31));
          cfg_fixed_dest = 4'($urandom_range(0, 15));
        end
        send_beat($urandom, i == len - 1);
        if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      end
    end
    drain();
    rand_ready = 0; m_if.tready = 1'b1;
    dest_log.delete();

    cfg_mode = 1'b0; cfg_num_active = 5'd4;
    send_beat($urandom, 1'b0);
    send_beat($urandom, 1'b0);
    resetn = 1'b0;
    @(negedge clk);
    chk_reset_outputs("mid_reset");
    @(posedge clk); #1; resetn = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("pkt_count_after_reset", sts_pkt_count, 0);
    dest_log.delete();
    send_pkt(3, 0);
    drain();
    q = {0}; check_log("after_reset", q);
    chk("pkt_count_after_reset_pkt", sts_pkt_count, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1, "timeout");
  end

endmodule
